// File: rtl/plugboard_arbiter_pkg.sv
// Shared plugboard constants and the arbiter state encoding.
// Imported by the plugboard arbiter top level.
package plugboard_arbiter_pkg;

  localparam int PB_DEPTH   = 26;
  localparam int PB_ADDR_W  = 5;
  localparam int PB_DATA_W  = 5;
  localparam int PB_NUM_REQ = 12;
  localparam int PB_ID_W    = 4;

  localparam logic [PB_DATA_W-1:0] PB_UNMAPPED = 5'd31;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } pb_state_e;

endpackage

// File: rtl/plugboard_arbiter_m10k.sv
// Single-port M10K-style plugboard storage with a registered read port.
// Contents are deliberately not reset.
module plugboard_arbiter_m10k #(
  parameter int DEPTH  = 26,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/plugboard_arbiter_rr.sv
// Round-robin arbiter over the drum requesters; the search starts at the
// pointer and the pointer moves just past each granted drum.
module plugboard_arbiter_rr #(
  parameter int NUM_REQ = 12,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] ptr;

  always_comb begin : scan
    int cand;
    logic [IDX_W-1:0] cand_idx;
    gnt      = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end
        cand_idx = IDX_W'(cand);
        if (!valid && req[cand_idx]) begin
          valid         = 1'b1;
          idx           = cand_idx;
          gnt[cand_idx] = 1'b1;
        end
      end
    end
  end

  // The pointer only advances on a drum grant, so loader wins leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/plugboard_arbiter.sv
// Shares the plugboard M10K between the loader and the drum requesters,
// and runs the clear sweep that marks every entry unmapped.
module plugboard_arbiter
  import plugboard_arbiter_pkg::*;
#(
  parameter int NUM_REQ = PB_NUM_REQ,
  parameter int ADDR_W  = PB_ADDR_W,
  parameter int DATA_W  = PB_DATA_W,
  parameter int DEPTH   = PB_DEPTH,
  parameter int ID_W    = PB_ID_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  input  logic                      init_req,
  input  logic                      init_we,
  input  logic [ADDR_W-1:0]         init_addr,
  input  logic [DATA_W-1:0]         init_wdata,
  output logic                      init_gnt,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rd_valid,
  output logic [ID_W-1:0]           rd_id,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      addr_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [DATA_W-1:0] SENTINEL = {DATA_W{1'b1}};

  pb_state_e         state, state_next;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              clear_last;
  logic              drum_en, drum_valid;
  logic [IDX_W-1:0]  drum_idx;
  logic              acc_valid, acc_we, addr_bad;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [ID_W-1:0]   acc_id;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_q;
  logic              rd_bad;

  // Grants are held off while reset is asserted so every output reads zero.
  assign init_gnt   = (state == ST_IDLE) && init_req && reset;
  assign drum_en    = (state == ST_IDLE) && !init_req && reset;
  assign clear_busy = (state == ST_CLEAR);
  assign clear_last = (state == ST_CLEAR) && (sweep_cnt == ADDR_W'(DEPTH - 1));

  plugboard_arbiter_rr #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr (
    .clk  (clk),
    .reset(reset),
    .en   (drum_en),
    .req  (req),
    .gnt  (gnt),
    .idx  (drum_idx),
    .valid(drum_valid)
  );

  always_comb begin
    acc_valid = init_gnt | drum_valid;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_id    = '0;
    if (init_gnt) begin
      acc_we    = init_we;
      acc_addr  = init_addr;
      acc_wdata = init_wdata;
      acc_id    = ID_W'(NUM_REQ);
    end else if (drum_valid) begin
      acc_we    = req_we[drum_idx];
      acc_addr  = req_addr[ADDR_W*int'(drum_idx) +: ADDR_W];
      acc_wdata = req_wdata[DATA_W*int'(drum_idx) +: DATA_W];
      acc_id    = ID_W'(drum_idx);
    end
    addr_bad = acc_valid && (int'(acc_addr) >= DEPTH);
  end

  // The sweep owns the memory port outright; otherwise the granted access does.
  always_comb begin
    mem_we    = acc_valid && acc_we && !addr_bad;
    mem_addr  = acc_addr;
    mem_wdata = acc_wdata;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = sweep_cnt;
      mem_wdata = SENTINEL;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_start) state_next = ST_CLEAR;
      ST_CLEAR: if (clear_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  plugboard_arbiter_m10k #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .q    (mem_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sweep_cnt  <= '0;
      rd_valid   <= 1'b0;
      rd_id      <= '0;
      rd_bad     <= 1'b0;
      addr_err   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      sweep_cnt  <= (state == ST_CLEAR && !clear_last) ? sweep_cnt + ADDR_W'(1) : '0;
      rd_valid   <= acc_valid && !acc_we;
      rd_id      <= (acc_valid && !acc_we) ? acc_id : '0;
      rd_bad     <= acc_valid && !acc_we && addr_bad;
      addr_err   <= addr_bad;
      clear_done <= clear_last;
    end
  end

  // Out-of-range reads never touch the array and report the unmapped value.
  assign rd_data = !rd_valid ? '0 : (rd_bad ? SENTINEL : mem_q);

endmodule

// File: tb/tb_plugboard_arbiter.sv
// Self-checking bench for plugboard_arbiter: directed vectors, hand-written
// corner sequences and a randomized phase against an array-based model.
module tb_plugboard_arbiter;

  localparam int N     = 12;
  localparam int AW    = 5;
  localparam int DW    = 5;
  localparam int DEPTH = 26;
  localparam int IW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear_start, clear_busy, clear_done;
  logic            init_req, init_we, init_gnt;
  logic [AW-1:0]   init_addr;
  logic [DW-1:0]   init_wdata;
  logic [N-1:0]    req, req_we, gnt;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic            rd_valid, addr_err;
  logic [IW-1:0]   rd_id;
  logic [DW-1:0]   rd_data;

  always #5 clk = ~clk;

  plugboard_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .init_req   (init_req),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_wdata (init_wdata),
    .init_gnt   (init_gnt),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rd_valid   (rd_valid),
    .rd_id      (rd_id),
    .rd_data    (rd_data),
    .addr_err   (addr_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plugboard contents (-1 = unknown), pointer, sweep progress.
  int mdl [DEPTH];
  int rr_m, sweep_left, win;
  bit done_exp, pv, perr;
  int pid, pdata;

  logic [N-1:0]  s_gnt;
  logic          s_init_gnt, s_busy, s_done, s_rd_valid, s_addr_err;
  logic [DW-1:0] s_rd_data;
  logic [IW-1:0] s_rd_id;

  typedef struct {
    bit           ireq;
    logic [N-1:0] rq;
    bit           exp_init;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t tbl [11];

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit ireq, input bit iwe, input int iaddr, input int idata,
                               input logic [N-1:0] rq, input logic [N-1:0] rwe, input bit cs);
    init_req    = ireq;
    init_we     = iwe;
    init_addr   = AW'(iaddr);
    init_wdata  = DW'(idata);
    req         = rq;
    req_we      = rwe;
    clear_start = cs;
  endtask

  task automatic setDrum(input int i, input int a, input int d);
    req_addr[AW*i +: AW]  = AW'(a);
    req_wdata[DW*i +: DW] = DW'(d);
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic modelReset();
    rr_m = 0; sweep_left = 0; done_exp = 0; pv = 0; perr = 0; win = -1;
  endtask

  function automatic int expWinner();
    if (sweep_left > 0 || !reset) return -1;
    if (init_req) return N;
    for (int k = 0; k < N; k++) begin
      if (req[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput();
    int w;
    logic [N-1:0] eg;
    w  = expWinner();
    eg = '0;
    if (w >= 0 && w < N) eg[w] = 1'b1;
    s_gnt = gnt; s_init_gnt = init_gnt; s_busy = clear_busy; s_done = clear_done;
    s_rd_valid = rd_valid; s_rd_data = rd_data; s_rd_id = rd_id; s_addr_err = addr_err;
    compare("init_gnt", int'(init_gnt), int'(w == N));
    compare("gnt", int'(gnt), int'(eg));
    compare("clear_busy", int'(clear_busy), int'(sweep_left > 0));
    compare("clear_done", int'(clear_done), int'(done_exp));
    compare("rd_valid", int'(rd_valid), int'(pv));
    compare("addr_err", int'(addr_err), int'(perr));
    if (pv) begin
      compare("rd_id", int'(rd_id), pid);
      if (pdata >= 0) compare("rd_data", int'(rd_data), pdata);
    end
    win = w;
  endtask

  task automatic updateModel();
    int a, wd;
    bit we_, bad;
    pv = 0; perr = 0;
    if (win >= 0) begin
      if (win == N) begin
        a = int'(init_addr); we_ = init_we; wd = int'(init_wdata);
      end else begin
        a = int'(req_addr[AW*win +: AW]); we_ = req_we[win]; wd = int'(req_wdata[DW*win +: DW]);
        rr_m = (win + 1) % N;
      end
      bad  = (a >= DEPTH);
      perr = bad;
      if (we_) begin
        if (!bad) mdl[a] = wd;
      end else begin
        pv = 1; pid = win; pdata = bad ? 31 : mdl[a];
      end
    end
    done_exp = 0;
    if (sweep_left > 0) begin
      mdl[DEPTH - sweep_left] = 31;
      sweep_left--;
      done_exp = (sweep_left == 0);
    end else if (clear_start) begin
      sweep_left = DEPTH;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic resetCheck(input string tag);
    compare({tag, "_clear_busy"}, int'(clear_busy), 0);
    compare({tag, "_clear_done"}, int'(clear_done), 0);
    compare({tag, "_init_gnt"}, int'(init_gnt), 0);
    compare({tag, "_gnt"}, int'(gnt), 0);
    compare({tag, "_rd_valid"}, int'(rd_valid), 0);
    compare({tag, "_rd_id"}, int'(rd_id), 0);
    compare({tag, "_rd_data"}, int'(rd_data), 0);
    compare({tag, "_addr_err"}, int'(addr_err), 0);
  endtask

  initial begin
    int busy_cnt, done_at;
    logic [N-1:0] rq, rwe;

    tbl[0]  = '{0, 12'h089, 0, 12'h001};
    tbl[1]  = '{0, 12'h089, 0, 12'h008};
    tbl[2]  = '{0, 12'h089, 0, 12'h080};
    tbl[3]  = '{0, 12'h089, 0, 12'h001};
    tbl[4]  = '{0, 12'h089, 0, 12'h008};
    tbl[5]  = '{0, 12'h089, 0, 12'h080};
    tbl[6]  = '{1, 12'h020, 1, 12'h000};
    tbl[7]  = '{0, 12'h020, 0, 12'h020};
    tbl[8]  = '{0, 12'h022, 0, 12'h002};
    tbl[9]  = '{0, 12'h022, 0, 12'h020};
    tbl[10] = '{0, 12'h000, 0, 12'h000};

    reset = 1'b0;
    idleInputs();
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = -1;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    resetCheck("reset");
    reset = 1'b1;

    // Full clear sweep: 26 busy cycles, done on the 27th after the start cycle.
    applyStimulus(0, 0, 0, 0, '0, '0, 1);
    cycle();
    idleInputs();
    busy_cnt = 0; done_at = 0;
    for (int c = 1; c <= 30; c++) begin
      cycle();
      if (s_busy) busy_cnt++;
      if (s_done && done_at == 0) done_at = c;
    end
    compare("sweep_len", busy_cnt, 26);
    compare("done_cycle", done_at, 27);

    // Loader reads both ends of the cleared table.
    applyStimulus(1, 0, 0, 0, '0, '0, 0);
    cycle();
    applyStimulus(1, 0, 25, 0, '0, '0, 0);
    cycle();
    compare("rd0_data", int'(s_rd_data), 31);
    compare("rd0_id", int'(s_rd_id), 12);
    idleInputs();
    cycle();
    compare("rd25_data", int'(s_rd_data), 31);
    compare("rd25_id", int'(s_rd_id), 12);

    // Read-after-write on consecutive cycles.
    applyStimulus(1, 1, 4, 17, '0, '0, 0);
    cycle();
    applyStimulus(1, 0, 4, 0, '0, '0, 0);
    cycle();
    idleInputs();
    cycle();
    compare("raw_valid", int'(s_rd_valid), 1);
    compare("raw_data", int'(s_rd_data), 17);
    compare("raw_id", int'(s_rd_id), 12);

    // Round-robin and loader-priority vectors; each drum reads its own index.
    for (int i = 0; i < N; i++) setDrum(i, i, 0);
    foreach (tbl[r]) begin
      applyStimulus(tbl[r].ireq, 0, 0, 0, tbl[r].rq, '0, 0);
      cycle();
      compare($sformatf("tbl%0d_gnt", r), int'(s_gnt), int'(tbl[r].exp_gnt));
      compare($sformatf("tbl%0d_init", r), int'(s_init_gnt), int'(tbl[r].exp_init));
    end
    idleInputs();
    cycle();

    // Out-of-range read then write from drum 2.
    setDrum(2, 30, 3);
    applyStimulus(0, 0, 0, 0, 12'h004, '0, 0);
    cycle();
    compare("oor_gnt", int'(s_gnt), 4);
    idleInputs();
    cycle();
    compare("oor_data", int'(s_rd_data), 31);
    compare("oor_err", int'(s_addr_err), 1);
    applyStimulus(0, 0, 0, 0, 12'h004, 12'h004, 0);
    cycle();
    idleInputs();
    cycle();
    compare("oor_wr_err", int'(s_addr_err), 1);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1, 0, a, 0, '0, '0, 0);
      cycle();
    end
    idleInputs();
    cycle();

    // Randomized traffic with occasional sweeps and bad addresses.
    for (int c = 0; c < 400; c++) begin
      rq  = N'($urandom) & N'($urandom);
      rwe = N'($urandom);
      for (int i = 0; i < N; i++) setDrum(i, $urandom_range(0, 29), $urandom_range(0, 31));
      applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 29),
                    $urandom_range(0, 31), rq, rwe, ($urandom_range(0, 49) == 0));
      cycle();
    end
    idleInputs();
    repeat (30) cycle();

    // Reset ten cycles into a sweep: no done pulse, partial clear survives.
    applyStimulus(1, 1, 20, 9, '0, '0, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, '0, '0, 1);
    cycle();
    idleInputs();
    repeat (10) cycle();
    reset = 1'b0;
    #1;
    resetCheck("midsweep");
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) cycle();
    applyStimulus(1, 0, 5, 0, '0, '0, 0);
    cycle();
    applyStimulus(1, 0, 20, 0, '0, '0, 0);
    cycle();
    compare("keep5_data", int'(s_rd_data), 31);
    idleInputs();
    cycle();
    compare("keep20_data", int'(s_rd_data), 9);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plugboard_arbiter.md
Name: plugboard_arbiter

Overview:
- Owns the single shared plugboard M10K (26 x 5-bit) and shares it between one init/loader port and NUM_REQ drum requesters.
- Grants at most one access (read or write) per cycle. Returns tagged read data one cycle later.
- Sequences a hardware clear sweep that marks every plugboard entry unmapped before a new bombe run.
- Sits inside the drumbank and replaces ad-hoc muxing of the plugboard ports by drum index.

Parameters:
- NUM_REQ, 12, number of drum requesters.
- ADDR_W, 5, plugboard address width.
- DATA_W, 5, plugboard entry width.
- DEPTH, 26, number of plugboard entries (letters).
- ID_W, 4, width of the read-response tag; must satisfy 2^ID_W >= NUM_REQ+1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- clear_start  input  1  one-cycle pulse: begin clear sweep
- clear_busy  output  1  high while the sweep runs
- clear_done  output  1  one-cycle pulse after the last sweep write
- init_req  input  1  loader access request
- init_we  input  1  1=write, 0=read
- init_addr  input  ADDR_W  loader address
- init_wdata  input  DATA_W  loader write data
- init_gnt  output  1  loader access accepted this cycle
- req  input  NUM_REQ  per-drum request
- req_we  input  NUM_REQ  per-drum write flag
- req_addr  input  ADDR_W*NUM_REQ  packed drum addresses; drum i at [ADDR_W*i +: ADDR_W]
- req_wdata  input  DATA_W*NUM_REQ  packed drum write data
- gnt  output  NUM_REQ  one-hot drum grant, at most one bit set
- rd_valid  output  1  read response valid
- rd_id  output  ID_W  response tag: 0..NUM_REQ-1 = drum index, NUM_REQ = loader
- rd_data  output  DATA_W  read data
- addr_err  output  1  pulse: granted access had addr >= DEPTH

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, sweep counter=0. All outputs are 0. Memory contents are not cleared.
- States:
  - IDLE: arbitrate accesses.
  - CLEAR: sweep active.
  - IDLE->CLEAR on clear_start.
  - CLEAR->IDLE after the write to address DEPTH-1. clear_done pulses in the first IDLE cycle.
  - clear_start while in CLEAR is ignored.
- CLEAR:
  - One write per cycle of sentinel {DATA_W{1'b1}} (31) to address 0,1,...,DEPTH-1. The sweep lasts exactly DEPTH cycles.
  - clear_busy=1 for the whole sweep.
  - init_gnt=0 and gnt=0 throughout the sweep; requesters simply hold req.
- IDLE arbitration, combinational within the cycle:
  - Priority is loader over drums.
  - Drums use round-robin starting at rr_ptr.
  - An access is accepted in cycle t when its request and grant are both high.
  - After a drum i grant, rr_ptr <= (i+1) mod NUM_REQ. rr_ptr is unchanged when the loader wins or nothing is granted.
  - A cycle in which clear_start arrives still arbitrates normally; the sweep begins the next cycle.
- Memory access:
  - The granted address and data drive the M10K in cycle t.
  - A write lands at the edge ending cycle t.
  - A read gives rd_valid=1, rd_id=tag and rd_data=q in cycle t+1 (latency 1).
  - rd_valid is 0 for writes and idle cycles.
  - Read-after-write to the same address in consecutive cycles returns the new data.
- Address check: if the granted address is >= DEPTH:
  - The write is suppressed.
  - A read returns the sentinel 31 with rd_valid=1.
  - addr_err=1 in cycle t+1.
  - The grant is still given.
- Reset mid-sweep: aborts the sweep with no clear_done pulse. Memory is partially cleared; software must reissue clear_start.
- Requesters hold req, req_we, addr and wdata stable until they see a grant; the arbiter does not queue requests.

Decomposition:
- Shared package holds:
  - PB_DEPTH=26
  - PB_ADDR_W=5
  - PB_DATA_W=5
  - PB_UNMAPPED=5'd31
  - state encodings IDLE/CLEAR
- Natural sub-module: rr_arbiter (NUM_REQ-wide round-robin, pointer register, one-hot gnt).
- The existing M10K module is instantiated for storage.

Test Plan:
- Reset released, clear_start pulse -> clear_busy high for 26 cycles, clear_done pulse on cycle 27; loader reads of addr 0 and addr 25 return 31 with rd_id=12.
- Loader writes addr 4 <= 17, then reads addr 4 on the next cycle -> rd_valid, rd_data=17, rd_id=12 one cycle after the read grant.
- Drums 0, 3 and 7 request continuously (reads) -> grant order 0,3,7,0,3,7, each rd_id matching the drum one cycle after its grant.
- init_req and drum 5 both requesting in the same cycle -> init_gnt=1, gnt=0; drum 5 is granted the next cycle with rr_ptr honoured.
- Drum 2 reads addr 30 -> gnt[2]=1; next cycle rd_data=31 and addr_err=1; memory is unchanged when a write to addr 30 is also attempted.
- reset asserted at cycle 10 of a sweep -> outputs go to 0 immediately with no clear_done pulse; addr 5 keeps 31 and addr 20 keeps its pre-sweep value.
